// File: rtl/hello_world_qsys_seg_scan.sv
// Avalon-MM scan controller: per-digit hex registers, one shared 7-segment bus and blanked digit strobes.
// Optional macro SEG_SCAN_DP_EN adds a per-digit decimal point (DIGITk[4]) and the dp_out port.

module hello_world_qsys_seg_scan #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en
`ifdef SEG_SCAN_DP_EN
  ,
  output logic                  dp_out
`endif
);

`ifdef SEG_SCAN_DP_EN
  localparam int unsigned DIGIT_W = 5;
`else
  localparam int unsigned DIGIT_W = 4;
`endif
  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [6:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [2:0]  CTRL_ADDR   = 3'd6;
  localparam logic [2:0]  STATUS_ADDR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  logic [DIGIT_W-1:0]    r_digit [NUM_DIGITS];
  logic                  r_ctrl_en;
  state_t                r_state;
  logic [2:0]            r_index;
  logic [CNT_W-1:0]      r_cnt;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig;

  logic                  w_wr;
  logic [DIGIT_W-1:0]    w_cur_digit;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [6:0]            w_seg_on;
  logic [NUM_DIGITS-1:0] w_dig_on;
  logic                  w_unused_wdata;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'h0:    seg_decode = 7'h3F;
      4'h1:    seg_decode = 7'h06;
      4'h2:    seg_decode = 7'h5B;
      4'h3:    seg_decode = 7'h4F;
      4'h4:    seg_decode = 7'h66;
      4'h5:    seg_decode = 7'h6D;
      4'h6:    seg_decode = 7'h7D;
      4'h7:    seg_decode = 7'h07;
      4'h8:    seg_decode = 7'h7F;
      4'h9:    seg_decode = 7'h6F;
      4'hA:    seg_decode = 7'h77;
      4'hB:    seg_decode = 7'h7C;
      4'hC:    seg_decode = 7'h39;
      4'hD:    seg_decode = 7'h5E;
      4'hE:    seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata[31:DIGIT_W];

  // Register file: digit codes and enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_digit[k] <= '0;
      r_ctrl_en <= 1'b0;
    end else if (w_wr) begin
      for (int k = 0; k < NUM_DIGITS; k++)
        if (address == 3'(k)) r_digit[k] <= writedata[DIGIT_W-1:0];
      if (address == CTRL_ADDR) r_ctrl_en <= writedata[0];
    end
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (address == 3'(k)) readdata = 32'(r_digit[k]);
    if (address == CTRL_ADDR)   readdata = {31'b0, r_ctrl_en};
    if (address == STATUS_ADDR) readdata = {27'b0, r_state, r_index};
  end

  // Code and strobe for the digit about to be latched
  always_comb begin
    w_cur_digit = '0;
    w_onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_index == 3'(k)) begin
        w_cur_digit = r_digit[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  assign w_seg_on = seg_decode(w_cur_digit[3:0]) ^ SEG_OFF;
  assign w_dig_on = w_onehot ^ DIG_OFF;

`ifdef SEG_SCAN_DP_EN
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  logic r_dp;
  logic w_dp_on;
  assign w_dp_on = w_cur_digit[4] ^ DP_OFF;
  assign dp_out  = r_dp;
`endif

  // Scan sequencer; outputs only change while every digit is off
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_seg   <= SEG_OFF;
      r_dig   <= DIG_OFF;
`ifdef SEG_SCAN_DP_EN
      r_dp    <= DP_OFF;
`endif
    end else if (!r_ctrl_en) begin
      r_state <= IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_seg   <= SEG_OFF;
      r_dig   <= DIG_OFF;
`ifdef SEG_SCAN_DP_EN
      r_dp    <= DP_OFF;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= BLANK;
          r_index <= '0;
          r_cnt   <= '0;
        end
        BLANK: begin
          if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= DRIVE;
            r_seg   <= w_seg_on;
            r_dig   <= w_dig_on;
`ifdef SEG_SCAN_DP_EN
            r_dp    <= w_dp_on;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_cnt   <= '0;
            r_state <= BLANK;
            r_seg   <= SEG_OFF;
            r_dig   <= DIG_OFF;
`ifdef SEG_SCAN_DP_EN
            r_dp    <= DP_OFF;
`endif
            r_index <= (r_index == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_index + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign seg_out = r_seg;
  assign dig_en  = r_dig;

endmodule

// File: tb/tb_hello_world_qsys_seg_scan.sv
// Scoreboard bench for hello_world_qsys_seg_scan: planned runs push expected drive
// intervals; a monitor reconstructs each lit interval from the outputs and compares.

module tb_hello_world_qsys_seg_scan;
  localparam int N    = 4;
  localparam int SCAN = 4;
  localparam int BL   = 2;
  localparam int P    = SCAN + BL;
`ifdef SEG_SCAN_DP_EN
  localparam logic [31:0] DMASK = 32'h1F;
`else
  localparam logic [31:0] DMASK = 32'h0F;
`endif

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        tb_dp;

`ifdef SEG_SCAN_DP_EN
  logic dp_out;
  assign tb_dp = dp_out;
`else
  assign tb_dp = 1'b1;
`endif

  hello_world_qsys_seg_scan #(
    .NUM_DIGITS(N), .SCAN_DIV(SCAN), .BLANK_CYCLES(BL),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_out(seg_out), .dig_en(dig_en)
`ifdef SEG_SCAN_DP_EN
    , .dp_out(dp_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         start;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    int         len;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          h_edge[$], h_addr[$], h_val[$];
  int          p_edge[$], p_addr[$], r_cyc[$];
  logic [31:0] p_data[$];
  logic [6:0]  HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Digit value in force just before edge s (reset value 0)
  function automatic int digit_at(input int d, input int s);
    int v;
    v = 0;
    for (int i = 0; i < h_edge.size(); i++)
      if (h_addr[i] == d && h_edge[i] < s) v = h_val[i];
    return v;
  endfunction

  // STATUS after edge c of a run whose enable took effect at edge te
  function automatic logic [31:0] status_at(input int te, input int c);
    int u, k, r, idx;
    if (c <= te) return 32'd0;
    u   = c - te - 1;
    k   = u / P;
    r   = u % P;
    idx = k % N;
    return (r < BL) ? 32'(16 + idx) : 32'(8 + idx);
  endfunction

  // Every digit slot starting no later than the stop edge is expected, truncated by the stop
  task automatic push_run(input int te, input int td);
    ev_t e;
    int  s, v, idx;
    for (int k = 0; te + BL + 1 + k * P <= td; k++) begin
      s       = te + BL + 1 + k * P;
      idx     = k % N;
      v       = digit_at(idx, s);
      e.start = s;
      e.dig   = 4'hF & ~(4'b0001 << idx);
      e.seg   = 7'h7F & ~HEX7[v % 16];
      e.dp    = ((v & 16) == 0);
      e.len   = (td + 1 - s < SCAN) ? td + 1 - s : SCAN;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: rebuilds lit intervals and checks glitch-free behaviour every cycle
  bit  m_on;
  bit  prev_on = 1'b0;
  ev_t cur;
  ev_t m_e;
  always @(negedge clk) begin
    m_on = (dig_en != 4'hF);
    if (m_on) chk("one_digit_on", 32'($countones(~dig_en)), 32'd1);
    else      chk("blank_outputs_off", 32'({tb_dp, seg_out}), 32'h0FF);
    if (m_on && !prev_on) begin
      cur.start = cyc;
      cur.dig   = dig_en;
      cur.seg   = seg_out;
      cur.dp    = tb_dp;
      cur.len   = 1;
    end else if (m_on) begin
      cur.len++;
      chk("drive_hold", 32'({dig_en, tb_dp, seg_out}), 32'({cur.dig, cur.dp, cur.seg}));
    end else if (prev_on) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_drive_start", 32'(cur.start), 32'hFFFF_FFFF);
      end else begin
        m_e = exp_q.pop_front();
        chk("drive_start", 32'(cur.start), 32'(m_e.start));
        chk("drive_digit", 32'(cur.dig), 32'(m_e.dig));
        chk("drive_seg", 32'({cur.dp, cur.seg}), 32'({m_e.dp, m_e.seg}));
        chk("drive_len", 32'(cur.len), 32'(m_e.len));
      end
    end
    prev_on = m_on;
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    if (int'(a) < N) begin
      h_edge.push_back(cyc + 1);
      h_addr.push_back(int'(a));
      h_val.push_back(int'(d & DMASK));
    end
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    address = a;
    #1;
    chk(nm, readdata, exp);
    @(negedge clk);
  endtask

  // mode 0: disable then check STATUS; mode 1: disable, return at once; mode 2: reset mid-run
  task automatic do_run(input int len, input int mode);
    int te, td;
    bit found;
    te = cyc + 1;
    td = te + len;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd6; writedata = 32'hA5A5_A5A5;
    for (int i = 0; i < p_edge.size(); i++) begin
      p_edge[i] = p_edge[i] + te;
      if (p_addr[i] < N) begin
        h_edge.push_back(p_edge[i]);
        h_addr.push_back(p_addr[i]);
        h_val.push_back(int'(p_data[i] & DMASK));
      end
    end
    for (int i = 0; i < r_cyc.size(); i++) r_cyc[i] = r_cyc[i] + te;
    if (mode != 2) begin
      p_edge.push_back(td); p_addr.push_back(6); p_data.push_back(32'h5A5A_5A5A);
    end
    push_run(te, td);
    forever begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      if (mode == 2 && cyc == td) begin
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", 32'({dig_en, tb_dp, seg_out}), 32'h0FFF);
        break;
      end
      if (mode == 1 && cyc == td) break;
      if (mode == 0 && cyc == td + 1) begin
        address = 3'd7;
        #1 chk("status_after_disable", readdata, 32'd0);
        break;
      end
      found = 1'b0;
      for (int i = 0; i < p_edge.size(); i++) begin
        if (p_edge[i] == cyc + 1) begin
          chipselect = 1'b1; write_n = 1'b0;
          address = 3'(p_addr[i]); writedata = p_data[i];
          found = 1'b1;
        end
      end
      if (!found) begin
        for (int i = 0; i < r_cyc.size(); i++) begin
          if (r_cyc[i] == cyc) begin
            address = 3'd7;
            #1 chk("status_mid_run", readdata, status_at(te, cyc));
          end
        end
      end
    end
    p_edge.delete(); p_addr.delete(); p_data.delete(); r_cyc.delete();
    if (mode == 2) begin
      repeat (3) @(negedge clk);
      h_edge.delete(); h_addr.delete(); h_val.delete();
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, "post_reset_readback");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, %0d checks so far", n_tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] vals [N];
    int          nw, len, off, a, mode;
    bit          dup;

    repeat (10) @(negedge clk);
    chk("reset_outputs", 32'({dig_en, tb_dp, seg_out}), 32'h0FFF);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, "reset_readback");

    // Directed frame: 1,2,3,8; rewrite digit 1 during its drive; re-enable back-to-back
    wr(3'd0, 32'h0000_0001);
    wr(3'd1, 32'h0000_00E2);
    wr(3'd2, 32'h0000_0003);
    wr(3'd3, 32'h0000_0008);
    rd(3'd1, 32'h2, "digit_readback_masked");
    rd(3'd3, 32'h8, "digit_readback");
    wr(3'd4, 32'h0000_000F);
    rd(3'd4, 32'd0, "unused_addr_read");
    p_edge.push_back(10); p_addr.push_back(1); p_data.push_back(32'd0);
    r_cyc.push_back(4); r_cyc.push_back(8);
    do_run(53, 1);
    do_run(BL + 1 + P + 1, 2);

    for (int it = 0; it < 6; it++) begin
      for (int d = 0; d < N; d++) begin
        vals[d] = $urandom;
        wr(3'(d), vals[d]);
      end
      for (int d = 0; d < N; d++) rd(3'(d), vals[d] & DMASK, "rand_digit_readback");
      wr(3'(4 + (it % 2)), $urandom);
      rd(3'(4 + (it % 2)), 32'd0, "rand_unused_read");
      len = $urandom_range(60, 2);
      nw  = $urandom_range(3, 0);
      for (int j = 0; j < nw; j++) begin
        off = $urandom_range(len - 1, 1);
        dup = 1'b0;
        foreach (p_edge[q]) if (p_edge[q] == off) dup = 1'b1;
        if (!dup) begin
          a = $urandom_range(7, 0);
          if (a == 6) a = 5;
          p_edge.push_back(off); p_addr.push_back(a); p_data.push_back($urandom);
        end
      end
      r_cyc.push_back($urandom_range(len - 1, 0));
      r_cyc.push_back($urandom_range(len - 1, 0));
      mode = (it == 5) ? 2 : $urandom_range(1, 0);
      do_run(len, mode);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hello_world_qsys_seg_scan.md
Name: hello_world_qsys_seg_scan

Overview:
Avalon-MM slave scan controller that time-multiplexes one shared 7-segment bus across NUM_DIGITS common-anode/cathode digits. Software writes 4-bit hex codes per digit and an enable bit. The block decodes each code, then sequences digit enables with fixed drive and blanking intervals. It replaces per-digit 7-bit output PIOs in the clock design with one shared segment bus plus digit strobes.

Parameters:
NUM_DIGITS, 6, number of scanned digits (legal 1..6)
SCAN_DIV, 50000, clk cycles each digit is driven (>=2)
BLANK_CYCLES, 16, clk cycles all digits off between digits (>=1)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)
DIG_ACTIVE_LOW, 1, 1 = digit enables inverted (on = 0)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, combinational from address, zero wait states
seg_out  output  7  registered segments; bit0=a ... bit6=g
dig_en  output  NUM_DIGITS  registered digit enables; bit k = digit k

Behaviour:
- Reset (async, reset_n=0) values:
  - digit regs = 0; ctrl = 0; state = IDLE; index = 0; counters = 0.
  - seg_out = all segments off: 7'h7F if SEG_ACTIVE_LOW, else 7'h00.
  - dig_en = all off: all 1s if DIG_ACTIVE_LOW, else all 0s.
- Register map. A write occurs when chipselect=1 and write_n=0.
  - addr 0..NUM_DIGITS-1: DIGITk[3:0], hex code for digit k. Bits above 3 are ignored and read 0.
  - addr 6: CTRL[0] = enable. Other bits read 0.
  - addr 7: STATUS, read-only. [2:0] = current index; [4:3] = state (0 IDLE, 1 DRIVE, 2 BLANK).
  - Unused addresses read 0; writes to them are ignored.
- Decode (active-high form, before SEG_ACTIVE_LOW inversion):
  - Standard hex: 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07, 8->7F, 9->6F.
  - A->77, b->7C, C->39, d->5E, E->79, F->71.
- FSM:
  - IDLE: outputs off. When enable=1, go to BLANK with index=0 and counter=0.
  - BLANK: outputs off for BLANK_CYCLES cycles.
    - On the last cycle, latch decode(DIGIT[index]) into seg_out and assert dig_en[index]. Go to DRIVE.
  - DRIVE: hold seg_out and dig_en for SCAN_DIV cycles.
    - On the last cycle, turn outputs off and go to BLANK.
    - index increments, wrapping from NUM_DIGITS-1 to 0.
- Latency: from enable write to first dig_en assert is BLANK_CYCLES+1 cycles. Full frame = NUM_DIGITS*(SCAN_DIV+BLANK_CYCLES) cycles.
- Glitch-free rules:
  - seg_out changes only while all digits are off.
  - At most one dig_en bit is active at any time.
- Write to the currently driven digit during DRIVE: the register updates immediately. The display does not change until that digit's next DRIVE.
- Enable cleared in any state: the next cycle is IDLE with outputs off and index=0. No partial-phase completion.
- Enable cleared and set in consecutive writes: restarts cleanly from BLANK with index 0.
- Reset asserted mid-DRIVE: outputs go off immediately (async); all state returns to reset values.
- NUM_DIGITS=1: index stays 0; alternates BLANK/DRIVE.

Optional Feature:
SEG_SCAN_DP_EN
- Defined:
  - Each DIGITk register gains bit 4 = decimal point (readable).
  - Adds output port dp_out (1 bit), obeying SEG_ACTIVE_LOW.
  - dp_out is latched and blanked with seg_out.
  - Reset value: off.
- Undefined: bit 4 is ignored and reads 0; no dp_out port.

Test Plan:
(Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2, both active-low.)
- Reset, hold 10 cycles -> seg_out=7'h7F, dig_en=4'hF, readdata at addr 7 = 0.
- Write DIGIT0..3 = 1,2,3,8, then CTRL=1 -> 3 cycles later dig_en=4'hE, seg_out=7'h79 for 4 cycles. Then 2 cycles of 4'hF/7'h7F. Then dig_en=4'hD, seg_out=7'h24. Digit 3 shows 7'h00. Wraps to digit 0 after 24 cycles.
- During digit 1 DRIVE, write DIGIT1=0 -> seg_out stays 7'h24 until the phase ends. The next visit to digit 1 shows 7'h40.
- Write CTRL=0 mid-DRIVE -> next cycle dig_en=4'hF, seg_out=7'h7F, STATUS=0. Re-enable -> digit 0 first again.
- Assert reset_n=0 mid-DRIVE -> outputs off in the same cycle (async). All registers read 0.
- SEG_SCAN_DP_EN defined: write DIGIT2=5'h15 -> during digit 2 DRIVE, seg_out=7'h12 and dp_out=0. dp_out=1 at all other times.
